// File: rtl/ceyloniac_param_control_unit_if.sv
// Datapath <-> control-unit bundle: opcode/status toward the FSM, control strobes back.
// The datapath side uses the master modport; the control unit uses the slave modport.
interface ceyloniac_param_control_unit_if #(
  parameter int ALU_OP_WIDTH = 4,
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4,
  parameter int CAUSE_WIDTH  = 2
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    overflow;
  logic                    control_enable;
  logic                    mem_ready;
  logic                    irq;

  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    pc_write_cond;
  logic                    pc_write;
  logic                    i_or_d;
  logic                    mem_read;
  logic                    mem_write;
  logic                    mem_to_reg;
  logic                    ir_write;
  logic                    alu_src_a;
  logic                    reg_write;
  logic                    reg_dst;
  logic                    epc_write;
  logic                    cause_write;
  logic [1:0]              pc_source;
  logic [1:0]              alu_src_b;
  logic [CAUSE_WIDTH-1:0]  int_cause;
  logic [STATE_WIDTH-1:0]  current_state;

  modport master (
    output opcode, overflow, control_enable, mem_ready, irq,
    input  alu_op, pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, alu_src_a, reg_write, reg_dst, epc_write, cause_write,
           pc_source, alu_src_b, int_cause, current_state
  );

  modport slave (
    input  opcode, overflow, control_enable, mem_ready, irq,
    output alu_op, pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, alu_src_a, reg_write, reg_dst, epc_write, cause_write,
           pc_source, alu_src_b, int_cause, current_state
  );
endinterface

// File: rtl/ceyloniac_param_control_unit.sv
// Multi-cycle CPU control FSM with illegal-op, overflow and interrupt exception sequencing.
// Define CEYLONIAC_MEM_WAIT_EN to stall FETCH/MEM_READ/MEM_WRITE until mem_ready.
module ceyloniac_param_control_unit #(
  parameter int ALU_OP_WIDTH = 4,
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4,
  parameter int CAUSE_WIDTH  = 2
) (
  input logic clk,
  input logic reset,
  ceyloniac_param_control_unit_if.slave ctl
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXC_ILL   = 4'd10,
    S_EXC_OVF   = 4'd11,
    S_BIT_EXEC  = 4'd12,
    S_BIT_WB    = 4'd13,
    S_EXC_IRQ   = 4'd14,
    S_IDLE      = 4'd15
  } state_e;

  localparam logic [5:0] OP_LOAD   = 6'b010001;
  localparam logic [5:0] OP_STORE  = 6'b010010;
  localparam logic [5:0] OP_BRANCH = 6'b011001;
  localparam logic [5:0] OP_JUMP   = 6'b011100;
  localparam logic [5:0] OP_BIT_A  = 6'b010101;
  localparam logic [5:0] OP_BIT_B  = 6'b010110;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    pc_write_cond;
    logic                    pc_write;
    logic                    i_or_d;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    ir_write;
    logic                    alu_src_a;
    logic                    reg_write;
    logic                    reg_dst;
    logic                    epc_write;
    logic                    cause_write;
    logic [1:0]              pc_source;
    logic [1:0]              alu_src_b;
    logic [CAUSE_WIDTH-1:0]  int_cause;
  } ctrl_t;

  logic [STATE_WIDTH-1:0] state_q, state_d;
  state_e                 st, nxt, instr_end;
  logic                   code_unused, op_high, mem_done;
  logic                   irq_q, irq_pending, irq_edge, enter_irq;
  logic [5:0]             op6;
  ctrl_t                  c;

  // Codes above the 16 defined states only exist when the register is widened.
  generate
    if (STATE_WIDTH > 4) begin : g_wide_state
      assign code_unused = |state_q[STATE_WIDTH-1:4];
    end else begin : g_narrow_state
      assign code_unused = 1'b0;
    end
    if (OPCODE_WIDTH > 6) begin : g_wide_op
      assign op_high = |ctl.opcode[OPCODE_WIDTH-1:6];
    end else begin : g_narrow_op
      assign op_high = 1'b0;
    end
  endgenerate

`ifdef CEYLONIAC_MEM_WAIT_EN
  assign mem_done = ctl.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = ctl.mem_ready;
  assign mem_done         = 1'b1;
`endif

  assign st        = state_e'(state_q[3:0]);
  assign op6       = ctl.opcode[5:0];
  assign instr_end = irq_pending ? S_EXC_IRQ : S_FETCH;
  assign irq_edge  = ctl.irq & ~irq_q;
  assign enter_irq = !code_unused && (nxt == S_EXC_IRQ);

  // NOTE: every variable written in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:     nxt = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_high)                                 nxt = S_EXC_ILL;
        else if (op6 == OP_LOAD || op6 == OP_STORE)  nxt = S_MEM_ADDR;
        else if (op6[5:4] == 2'b00)                  nxt = S_R_EXEC;
        else if (op6 == OP_BRANCH)                   nxt = S_BRANCH;
        else if (op6 == OP_JUMP)                     nxt = S_JUMP;
        else if (op6 == OP_BIT_A || op6 == OP_BIT_B) nxt = S_BIT_EXEC;
        else                                         nxt = S_EXC_ILL;
      end
      S_MEM_ADDR:  nxt = (op6 == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = mem_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    nxt = instr_end;
      S_MEM_WRITE: nxt = mem_done ? instr_end : S_MEM_WRITE;
      S_R_EXEC:    nxt = S_R_WB;
      S_R_WB:      nxt = ctl.overflow ? S_EXC_OVF : instr_end;
      S_BRANCH:    nxt = instr_end;
      S_JUMP:      nxt = instr_end;
      S_EXC_ILL:   nxt = S_FETCH;
      S_EXC_OVF:   nxt = S_FETCH;
      S_BIT_EXEC:  nxt = S_BIT_WB;
      S_BIT_WB:    nxt = ctl.overflow ? S_EXC_OVF : instr_end;
      S_EXC_IRQ:   nxt = S_FETCH;
      S_IDLE:      nxt = S_FETCH;
    endcase
  end

  always_comb begin
    if (code_unused)             state_d = STATE_WIDTH'(S_IDLE);
    else if (ctl.control_enable) state_d = STATE_WIDTH'(nxt);
    else                         state_d = state_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= STATE_WIDTH'(S_IDLE);
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctl.control_enable) begin
        irq_q       <= ctl.irq;
        irq_pending <= irq_edge | (irq_pending & ~enter_irq);
      end
    end
  end

  always_comb begin
    c = '0;
    if (!code_unused) begin
      case (st)
        S_FETCH: begin
          c.mem_read  = 1'b1;
          c.ir_write  = mem_done;
          c.pc_write  = mem_done;
          c.alu_src_b = 2'b01;
        end
        S_DECODE:   c.alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          c.mem_read = 1'b1;
          c.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          c.mem_write = 1'b1;
          c.i_or_d    = 1'b1;
        end
        S_R_EXEC, S_R_WB: begin
          c.alu_src_a = 1'b1;
          c.alu_op    = ALU_OP_WIDTH'(op6[3:0]);
          c.reg_dst   = (st == S_R_WB);
          c.reg_write = (st == S_R_WB) && !ctl.overflow;
        end
        S_BIT_EXEC, S_BIT_WB: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'b10;
          c.alu_op    = '1;
          c.reg_write = (st == S_BIT_WB) && !ctl.overflow;
        end
        S_BRANCH: begin
          c.alu_src_a     = 1'b1;
          c.alu_op        = ALU_OP_WIDTH'(1);
          c.pc_write_cond = 1'b1;
          c.pc_source     = 2'b01;
        end
        S_JUMP: begin
          c.pc_write  = 1'b1;
          c.pc_source = 2'b10;
        end
        S_EXC_ILL, S_EXC_OVF, S_EXC_IRQ: begin
          c.epc_write   = 1'b1;
          c.cause_write = 1'b1;
          c.pc_write    = 1'b1;
          c.pc_source   = 2'b11;
          c.alu_src_b   = 2'b01;
          c.alu_op      = ALU_OP_WIDTH'(1);
          c.int_cause   = (st == S_EXC_ILL) ? CAUSE_WIDTH'(0) :
                          (st == S_EXC_OVF) ? CAUSE_WIDTH'(1) : CAUSE_WIDTH'(2);
        end
        default: ;
      endcase
    end
    // A held unit must not commit anything: all write/access strobes drop.
    if (!ctl.control_enable) begin
      c.pc_write      = 1'b0;
      c.pc_write_cond = 1'b0;
      c.ir_write      = 1'b0;
      c.reg_write     = 1'b0;
      c.mem_write     = 1'b0;
      c.mem_read      = 1'b0;
      c.epc_write     = 1'b0;
      c.cause_write   = 1'b0;
    end
  end

  assign ctl.alu_op        = c.alu_op;
  assign ctl.pc_write_cond = c.pc_write_cond;
  assign ctl.pc_write      = c.pc_write;
  assign ctl.i_or_d        = c.i_or_d;
  assign ctl.mem_read      = c.mem_read;
  assign ctl.mem_write     = c.mem_write;
  assign ctl.mem_to_reg    = c.mem_to_reg;
  assign ctl.ir_write      = c.ir_write;
  assign ctl.alu_src_a     = c.alu_src_a;
  assign ctl.reg_write     = c.reg_write;
  assign ctl.reg_dst       = c.reg_dst;
  assign ctl.epc_write     = c.epc_write;
  assign ctl.cause_write   = c.cause_write;
  assign ctl.pc_source     = c.pc_source;
  assign ctl.alu_src_b     = c.alu_src_b;
  assign ctl.int_cause     = c.int_cause;
  assign ctl.current_state = state_q;

endmodule

// File: tb/tb_ceyloniac_param_control_unit.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// state-by-state behavioural model of the control unit.
module tb_ceyloniac_param_control_unit;

`ifdef CEYLONIAC_MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
`else
  localparam bit MEM_WAIT = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] alu_op;
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       epc_write;
    logic       cause_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] int_cause;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_state;
  logic m_pend;
  logic m_irq_q;

  ceyloniac_param_control_unit_if bus ();

  ceyloniac_param_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic out_t act_outs();
    out_t o;
    o.alu_op        = bus.alu_op;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_write      = bus.pc_write;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.ir_write      = bus.ir_write;
    o.alu_src_a     = bus.alu_src_a;
    o.reg_write     = bus.reg_write;
    o.reg_dst       = bus.reg_dst;
    o.epc_write     = bus.epc_write;
    o.cause_write   = bus.cause_write;
    o.pc_source     = bus.pc_source;
    o.alu_src_b     = bus.alu_src_b;
    o.int_cause     = bus.int_cause;
    return o;
  endfunction

  // Expected control word for a state, straight from the per-state output table.
  function automatic out_t exp_outs(int s, logic [5:0] op, logic ovf, logic en, logic rdy);
    out_t o = '0;
    case (s)
      0: begin
        o.mem_read = 1; o.alu_src_b = 2'b01;
        o.ir_write = !MEM_WAIT || rdy; o.pc_write = !MEM_WAIT || rdy;
      end
      1: o.alu_src_b = 2'b11;
      2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3: begin o.mem_read = 1; o.i_or_d = 1; end
      4: begin o.reg_write = 1; o.mem_to_reg = 1; end
      5: begin o.mem_write = 1; o.i_or_d = 1; end
      6: begin o.alu_src_a = 1; o.alu_op = op[3:0]; end
      7: begin o.alu_src_a = 1; o.alu_op = op[3:0]; o.reg_dst = 1; o.reg_write = !ovf; end
      8: begin o.alu_src_a = 1; o.alu_op = 4'd1; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      9: begin o.pc_write = 1; o.pc_source = 2'b10; end
      10, 11, 14: begin
        o.epc_write = 1; o.cause_write = 1; o.pc_write = 1; o.pc_source = 2'b11;
        o.alu_src_b = 2'b01; o.alu_op = 4'd1;
        o.int_cause = (s == 10) ? 2'd0 : (s == 11) ? 2'd1 : 2'd2;
      end
      12: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 4'hF; end
      13: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 4'hF; o.reg_write = !ovf; end
      default: ;
    endcase
    if (!en) begin
      o.pc_write = 0; o.pc_write_cond = 0; o.ir_write = 0; o.reg_write = 0;
      o.mem_write = 0; o.mem_read = 0; o.epc_write = 0; o.cause_write = 0;
    end
    return o;
  endfunction

  function automatic int model_next(int s, logic [5:0] op, logic ovf, logic rdy, logic pend);
    int  fin  = pend ? 14 : 0;
    bit  hold = MEM_WAIT && !rdy;
    case (s)
      0:  return hold ? 0 : 1;
      1: begin
        case (op)
          6'd17, 6'd18: return 2;
          6'd25:        return 8;
          6'd28:        return 9;
          6'd21, 6'd22: return 12;
          default:      return (op[5:4] == 2'b00) ? 6 : 10;
        endcase
      end
      2:  return (op == 6'd17) ? 3 : 5;
      3:  return hold ? 3 : 4;
      4:  return fin;
      5:  return hold ? 5 : fin;
      6:  return 7;
      7, 13: return ovf ? 11 : fin;
      8, 9: return fin;
      12: return 13;
      default: return 0;
    endcase
  endfunction

  // One clock: drive inputs, check combinational outputs, advance the model at the edge.
  task automatic cycle(input logic en, input logic irq_v, input logic ovf, input logic [5:0] op,
                       input logic rdy);
    int nxt;
    bus.control_enable = en;
    bus.irq            = irq_v;
    bus.overflow       = ovf;
    bus.opcode         = op;
    bus.mem_ready      = rdy;
    #1;
    check("state", bus.current_state, m_state);
    check("outs", act_outs(), exp_outs(m_state, op, ovf, en, rdy));
    @(posedge clk);
    if (en) begin
      nxt     = model_next(m_state, op, ovf, rdy, m_pend);
      m_pend  = (irq_v && !m_irq_q) || (m_pend && nxt != 14);
      m_irq_q = irq_v;
      m_state = nxt;
    end
    #1;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_state", bus.current_state, 15);
    check("rst_outs", act_outs(), '0);
    @(posedge clk);
    #1;
    check("rst_hold_state", bus.current_state, 15);
    reset   = 1'b1;
    m_state = 15;
    m_pend  = 1'b0;
    m_irq_q = 1'b0;
  endtask

  task automatic run_seq(input string tag, input logic [5:0] op, input logic ovf, input int irq_at,
                         input int seq[8], input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_state"}, bus.current_state, seq[i]);
      if (i < n - 1) cycle(1'b1, (i == irq_at), ovf, op, 1'b1);
    end
  endtask

  logic [5:0] ops[8] = '{6'd17, 6'd18, 6'd25, 6'd28, 6'd21, 6'd22, 6'd3, 6'd63};

  initial begin
    logic [5:0] cur_op;
    reset              = 1'b1;
    bus.control_enable = 1'b1;
    bus.irq            = 1'b0;
    bus.overflow       = 1'b0;
    bus.opcode         = 6'd0;
    bus.mem_ready      = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("por_state", bus.current_state, 15);
    check("por_outs", act_outs(), '0);
    @(posedge clk);
    #1;
    check("por_hold_state", bus.current_state, 15);
    reset   = 1'b1;
    m_state = 15;
    m_pend  = 1'b0;
    m_irq_q = 1'b0;

    run_seq("load",    6'b010001, 1'b0, -1, '{15, 0, 1, 2, 3, 4, 0, 0}, 7);
    run_seq("r_ovf",   6'b000011, 1'b1, -1, '{0, 1, 6, 7, 11, 0, 0, 0}, 6);
    run_seq("illegal", 6'b111111, 1'b0, -1, '{0, 1, 10, 0, 0, 0, 0, 0}, 4);
    run_seq("irq",     6'b000001, 1'b0, 2,  '{0, 1, 6, 7, 14, 0, 0, 0}, 6);
    check("irq_cleared", dut.irq_pending, 1'b0);
    run_seq("store",   6'b010010, 1'b0, -1, '{0, 1, 2, 5, 0, 0, 0, 0}, 5);

    // Hold in FETCH with the unit disabled: state frozen, strobes low.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 6'b000001, 1'b1);
    check("hold_state", bus.current_state, 0);
    check("hold_mem_read", bus.mem_read, 1'b0);

    // Reset in the middle of an instruction restarts from IDLE.
    cycle(1'b1, 1'b0, 1'b0, 6'b000001, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 6'b000001, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 6'b000001, 1'b1);
    check("restart_state", bus.current_state, 0);

    cur_op = 6'b010001;
    for (int k = 0; k < 800; k++) begin
      if (m_state == 0 || m_state == 15)
        cur_op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), cur_op, ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got=running expected=finished", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/ceyloniac_param_control_unit.md
CEYLONIAC_PARAM_CONTROL_UNIT -- requirements
Module: ceyloniac_param_control_unit

Interface
REQ-001 Parameters SHALL be: ALU_OP_WIDTH, default 4, ALU op field width (>=4); OPCODE_WIDTH, default 6, opcode width (>=6); STATE_WIDTH, default 4, state register width (>=4); CAUSE_WIDTH, default 2, exception cause width (>=2).
REQ-002 Ports SHALL be: clk in 1, sole clock, rising edge; reset in 1, asynchronous active-low reset; opcode in OPCODE_WIDTH, IR opcode; overflow in 1, ALU overflow; control_enable in 1, run/hold; mem_ready in 1, memory access complete; irq in 1, external interrupt request.
REQ-003 Outputs SHALL be: alu_op ALU_OP_WIDTH; pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, epc_write, cause_write, 1 each; pc_source 2; alu_src_b 2; int_cause CAUSE_WIDTH; current_state STATE_WIDTH (state register mirror).

Function
REQ-004 States SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, EXC_ILL=10, EXC_OVF=11, BIT_EXEC=12, BIT_WB=13, EXC_IRQ=14, IDLE=15.
REQ-005 Outputs SHALL be a Moore decode of the state register (plus opcode for alu_op); unlisted outputs are 0.
REQ-006 FETCH: mem_read=1, i_or_d=0, ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=0, pc_source=00; next DECODE.
REQ-007 DECODE: alu_src_a=0, alu_src_b=11, alu_op=0; next by opcode: 010001/010010 -> MEM_ADDR; opcode[5:4]=00 -> R_EXEC; 011001 -> BRANCH; 011100 -> JUMP; 010101/010110 -> BIT_EXEC; any other value, or any nonzero opcode bit above bit 5 -> EXC_ILL.
REQ-008 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0; next MEM_READ for 010001, MEM_WRITE for 010010.
REQ-009 MEM_READ: mem_read=1, i_or_d=1; next MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instruction end. MEM_WRITE: mem_write=1, i_or_d=1; instruction end.
REQ-010 R_EXEC/R_WB: alu_src_a=1, alu_src_b=00, alu_op=zero-extended opcode[3:0]; R_WB adds reg_dst=1, reg_write=!overflow; R_WB with overflow=1 -> EXC_OVF, else instruction end.
REQ-011 BIT_EXEC/BIT_WB: alu_src_a=1, alu_src_b=10, alu_op=all ones; BIT_WB adds reg_dst=0, reg_write=!overflow; overflow handling as R_WB.
REQ-012 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1, pc_write_cond=1, pc_source=01; instruction end. JUMP: pc_write=1, pc_source=10; instruction end.
REQ-013 EXC_ILL/EXC_OVF/EXC_IRQ: epc_write=1, cause_write=1, pc_write=1, pc_source=11, alu_src_a=0, alu_src_b=01, alu_op=1; int_cause=0/1/2 respectively; next FETCH.
REQ-014 irq_pending flag SHALL set on a 0->1 edge of irq (sampled in clk) and clear on entry to EXC_IRQ; a new edge in the same cycle as the clear keeps it set.
REQ-015 Instruction end SHALL go to EXC_IRQ if irq_pending=1, else FETCH; EXC_OVF takes priority over EXC_IRQ; irq is never taken mid-instruction or from an EXC state.
REQ-016 IDLE: all outputs 0; next FETCH when control_enable=1.
REQ-017 control_enable=0 SHALL hold state and irq_pending edge detection, and force pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, epc_write, cause_write to 0 in that cycle.
REQ-018 Unused state codes (STATE_WIDTH>4, or none at 4) SHALL go to IDLE next cycle with all outputs 0.

Reset
REQ-019 reset=0 SHALL immediately force state=IDLE, irq_pending=0, edge detector=0, all outputs 0, regardless of clk or control_enable.
REQ-020 Reset release mid-instruction SHALL restart from IDLE; no partial instruction resumes.

Configuration
REQ-021 With CEYLONIAC_MEM_WAIT_EN defined, FETCH, MEM_READ and MEM_WRITE SHALL hold until mem_ready=1, and FETCH asserts pc_write and ir_write only in the mem_ready=1 cycle; without it, mem_ready is ignored and each of these states lasts one cycle.

Verification
REQ-022 reset=0 then release, control_enable=1, opcode=010001 -> states 15,0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in state 4.
REQ-023 opcode=000011, overflow=1 in R_WB -> reg_write=0 in state 7, then state 11 with int_cause=1, epc_write=1, pc_source=11.
REQ-024 opcode=111111 -> DECODE to state 10, int_cause=0, cause_write=1, then FETCH.
REQ-025 irq pulse during R_EXEC of opcode=000001 -> R_WB completes with reg_write=1, next state 14 with int_cause=2, then FETCH, irq_pending=0.
REQ-026 CEYLONIAC_MEM_WAIT_EN defined, mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write=1 held for 4 cycles, then FETCH; control_enable=0 mid-FETCH -> state held, strobes 0.
